// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Stopwatch with centisecond resolution (MM:SS.CC) held as six BCD digits.
// A free-running 10 ms square wave (i_base_tick) is edge-detected; each rising
// edge advances the time by one centisecond while the stopwatch is RUNNING.
// Start/stop and clear are single-cycle command pulses. All outputs come
// straight from registers.
//
// Parameters
//   WRAP         1: roll over 59:59.99 -> 00:00.00; 0: saturate at 59:59.99.
//                Either way o_overflow is set when the maximum is passed.
//
// Ports
//   i_sclk       system clock, rising edge
//   i_reset      synchronous, active-high reset (highest priority)
//   i_base_tick  10 ms timebase square wave, i_sclk domain
//   i_start_stop command pulse: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING
//   i_clear      command pulse: zero the time, clear overflow, go IDLE
//   o_timerenb   timebase enable, high exactly while RUNNING
//   o_cs_*       centisecond digits (0-9, 0-9)
//   o_sec_*      second digits (ones 0-9, tens 0-5)
//   o_min_*      minute digits (ones 0-9, tens 0-5)
//   o_state      00 IDLE, 01 RUNNING, 10 PAUSED
//   o_overflow   sticky: count passed 59:59.99
// -----------------------------------------------------------------------------
module stopwatch_counter #(
  parameter bit WRAP = 1'b1
) (
  input  logic       i_sclk,
  input  logic       i_reset,
  input  logic       i_base_tick,
  input  logic       i_start_stop,
  input  logic       i_clear,
  output logic       o_timerenb,
  output logic [3:0] o_cs_ones,
  output logic [3:0] o_cs_tens,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic [1:0] o_state,
  output logic       o_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic       tick_prev_q;
  logic       timerenb_q, timerenb_d;
  logic       overflow_q, overflow_d;

  logic [3:0] cs_ones_q,  cs_ones_d;
  logic [3:0] cs_tens_q,  cs_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;

  // Incremented time (one centisecond later) and ripple carries.
  logic [3:0] inc_cs_ones, inc_cs_tens, inc_sec_ones;
  logic [3:0] inc_sec_tens, inc_min_ones, inc_min_tens;
  logic       c_cs_ones, c_cs_tens, c_sec_ones, c_sec_tens, c_min_ones;
  logic       at_max;

  logic       tick_rise;
  logic       count_en;

  assign tick_rise = i_base_tick & ~tick_prev_q;
  assign count_en  = tick_rise && (state_q == ST_RUNNING);

  // Ripple carry chain. The ">=" compares keep a digit from ever escaping its
  // legal range even if a register were somehow upset to an illegal code.
  always_comb begin
    c_cs_ones    = (cs_ones_q  >= 4'd9);
    c_cs_tens    = c_cs_ones  && (cs_tens_q  >= 4'd9);
    c_sec_ones   = c_cs_tens  && (sec_ones_q >= 4'd9);
    c_sec_tens   = c_sec_ones && (sec_tens_q >= 4'd5);
    c_min_ones   = c_sec_tens && (min_ones_q >= 4'd9);
    at_max       = c_min_ones && (min_tens_q >= 4'd5);

    inc_cs_ones  = c_cs_ones ? 4'd0 : cs_ones_q + 4'd1;

    inc_cs_tens  = cs_tens_q;
    if (c_cs_ones) begin
      inc_cs_tens = c_cs_tens ? 4'd0 : cs_tens_q + 4'd1;
    end

    inc_sec_ones = sec_ones_q;
    if (c_cs_tens) begin
      inc_sec_ones = c_sec_ones ? 4'd0 : sec_ones_q + 4'd1;
    end

    inc_sec_tens = sec_tens_q;
    if (c_sec_ones) begin
      inc_sec_tens = c_sec_tens ? 4'd0 : sec_tens_q + 4'd1;
    end

    inc_min_ones = min_ones_q;
    if (c_sec_tens) begin
      inc_min_ones = c_min_ones ? 4'd0 : min_ones_q + 4'd1;
    end

    // At 59:59.99 every digit rolls to zero here, which is exactly the WRAP=1
    // result; the saturating variant simply refuses to take this value.
    inc_min_tens = min_tens_q;
    if (c_min_ones) begin
      inc_min_tens = at_max ? 4'd0 : min_tens_q + 4'd1;
    end
  end

  // Next-state logic: clear beats start/stop, and any command beats a tick
  // arriving in the same cycle (the tick is dropped, not deferred).
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    cs_ones_d  = cs_ones_q;
    cs_tens_d  = cs_tens_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;

    if (i_clear) begin
      state_d    = ST_IDLE;
      overflow_d = 1'b0;
      cs_ones_d  = 4'd0;
      cs_tens_d  = 4'd0;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if (i_start_stop) begin
      case (state_q)
        ST_IDLE:    state_d = ST_RUNNING;
        ST_RUNNING: state_d = ST_PAUSED;
        ST_PAUSED:  state_d = ST_RUNNING;
        default:    state_d = ST_IDLE;
      endcase
    end else if (count_en) begin
      if (at_max) begin
        overflow_d = 1'b1;
      end
      if (!at_max || WRAP) begin
        cs_ones_d  = inc_cs_ones;
        cs_tens_d  = inc_cs_tens;
        sec_ones_d = inc_sec_ones;
        sec_tens_d = inc_sec_tens;
        min_ones_d = inc_min_ones;
        min_tens_d = inc_min_tens;
      end
    end else if (state_q != ST_IDLE && state_q != ST_RUNNING
                 && state_q != ST_PAUSED) begin
      // Unused encoding 2'b11: recover to IDLE.
      state_d = ST_IDLE;
    end

    // Registered copy of "next state is RUNNING" keeps o_timerenb in lockstep
    // with o_state without a combinational output path.
    timerenb_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      tick_prev_q <= 1'b0;
      timerenb_q  <= 1'b0;
      overflow_q  <= 1'b0;
      cs_ones_q   <= 4'd0;
      cs_tens_q   <= 4'd0;
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      tick_prev_q <= i_base_tick;
      timerenb_q  <= timerenb_d;
      overflow_q  <= overflow_d;
      cs_ones_q   <= cs_ones_d;
      cs_tens_q   <= cs_tens_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
    end
  end

  assign o_timerenb = timerenb_q;
  assign o_overflow = overflow_q;
  assign o_state    = state_q;
  assign o_cs_ones  = cs_ones_q;
  assign o_cs_tens  = cs_tens_q;
  assign o_sec_ones = sec_ones_q;
  assign o_sec_tens = sec_tens_q;
  assign o_min_ones = min_ones_q;
  assign o_min_tens = min_tens_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Drives a wrapping and a saturating stopwatch from the same stimulus. A
// reference model keeps the elapsed time as a plain centisecond count and
// derives the expected digits arithmetically; every cycle both instances are
// compared against it, and hand-computed literals pin key points.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

  localparam int MAX_CS = 359999;   // 59:59.99
  localparam int PRE_CS = 359997;   // 59:59.97

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic base_tick = 1'b0;
  logic ss = 1'b0;
  logic clr = 1'b0;

  logic       w_tenb, w_ovf;
  logic [3:0] w_cso, w_cst, w_so, w_st, w_mo, w_mt;
  logic [1:0] w_state;
  logic       s_tenb, s_ovf;
  logic [3:0] s_cso, s_cst, s_so, s_st, s_mo, s_mt;
  logic [1:0] s_state;

  stopwatch_counter #(.WRAP(1'b1)) u_wrap (
    .i_sclk(clk), .i_reset(rst), .i_base_tick(base_tick),
    .i_start_stop(ss), .i_clear(clr), .o_timerenb(w_tenb),
    .o_cs_ones(w_cso), .o_cs_tens(w_cst), .o_sec_ones(w_so),
    .o_sec_tens(w_st), .o_min_ones(w_mo), .o_min_tens(w_mt),
    .o_state(w_state), .o_overflow(w_ovf)
  );

  stopwatch_counter #(.WRAP(1'b0)) u_sat (
    .i_sclk(clk), .i_reset(rst), .i_base_tick(base_tick),
    .i_start_stop(ss), .i_clear(clr), .o_timerenb(s_tenb),
    .o_cs_ones(s_cso), .o_cs_tens(s_cst), .o_sec_ones(s_so),
    .o_sec_tens(s_st), .o_min_ones(s_mo), .o_min_tens(s_mt),
    .o_state(s_state), .o_overflow(s_ovf)
  );

  always #5 clk = ~clk;

  logic [23:0] w_time, s_time;
  assign w_time = {w_mt, w_mo, w_st, w_so, w_cst, w_cso};
  assign s_time = {s_mt, s_mo, s_st, s_so, s_cst, s_cso};

  // Reference model: index 0 = wrapping instance, 1 = saturating instance.
  int m_state = 0;            // 0 idle, 1 running, 2 paused
  bit m_tprev = 1'b0;
  int m_cnt [2] = '{0, 0};
  bit m_ovf [2] = '{1'b0, 1'b0};
  bit pre_req = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic logic [23:0] bcd_of(int cnt);
    int mins, secs, cs;
    mins = cnt / 6000;
    secs = (cnt / 100) % 60;
    cs   = cnt % 100;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
            4'(cs / 10), 4'(cs % 10)};
  endfunction

  always @(posedge clk) begin : model
    bit rise;
    rise = base_tick && !m_tprev;
    if (rst) begin
      m_state = 0;
      m_tprev = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
      end
    end else begin
      m_tprev = base_tick;
      if (pre_req) begin
        m_cnt[0] = PRE_CS;
        m_cnt[1] = PRE_CS;
      end
      if (clr) begin
        m_state = 0;
        for (int k = 0; k < 2; k++) begin
          m_cnt[k] = 0;
          m_ovf[k] = 1'b0;
        end
      end else if (ss) begin
        m_state = (m_state == 1) ? 2 : 1;
      end else if (m_state == 1 && rise) begin
        for (int k = 0; k < 2; k++) begin
          if (m_cnt[k] == MAX_CS) begin
            m_ovf[k] = 1'b1;
            m_cnt[k] = (k == 0) ? 0 : MAX_CS;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [27:0] exp0, exp1;
    exp0 = {bcd_of(m_cnt[0]), 2'(m_state), (m_state == 1), m_ovf[0]};
    exp1 = {bcd_of(m_cnt[1]), 2'(m_state), (m_state == 1), m_ovf[1]};
    check("cyc_wrap", {4'h0, w_time, w_state, w_tenb, w_ovf}, {4'h0, exp0});
    check("cyc_sat",  {4'h0, s_time, s_state, s_tenb, s_ovf}, {4'h0, exp1});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (chk_en) cmp_model();
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      base_tick = 1'b1; step();
      base_tick = 1'b0; step();
    end
  endtask

  task automatic pulse_ss();
    ss = 1'b1; step(); ss = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  // Both instances must be PAUSED. Loads 59:59.97 into the digit registers;
  // with the count frozen the registers then recirculate the loaded value.
  task automatic preload();
    chk_en  = 1'b0;
    pre_req = 1'b1;
    force u_wrap.min_tens_q = 4'd5; force u_wrap.min_ones_q = 4'd9;
    force u_wrap.sec_tens_q = 4'd5; force u_wrap.sec_ones_q = 4'd9;
    force u_wrap.cs_tens_q  = 4'd9; force u_wrap.cs_ones_q  = 4'd7;
    force u_sat.min_tens_q  = 4'd5; force u_sat.min_ones_q  = 4'd9;
    force u_sat.sec_tens_q  = 4'd5; force u_sat.sec_ones_q  = 4'd9;
    force u_sat.cs_tens_q   = 4'd9; force u_sat.cs_ones_q   = 4'd7;
    step();
    pre_req = 1'b0;
    release u_wrap.min_tens_q; release u_wrap.min_ones_q;
    release u_wrap.sec_tens_q; release u_wrap.sec_ones_q;
    release u_wrap.cs_tens_q;  release u_wrap.cs_ones_q;
    release u_sat.min_tens_q;  release u_sat.min_ones_q;
    release u_sat.sec_tens_q;  release u_sat.sec_ones_q;
    release u_sat.cs_tens_q;   release u_sat.cs_ones_q;
    step();
    chk_en = 1'b1;
    cmp_model();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rst_time", {8'h0, w_time}, 32'h000000);
    check("rst_ctrl", {28'h0, w_state, w_tenb, w_ovf}, 32'h0);
    check("rst_model", {8'h0, bcd_of(m_cnt[0])}, 32'h000000);

    // Start, 100 ticks -> 00:01.00 running
    pulse_ss();
    ticks(100);
    check("t100_time", {8'h0, w_time}, 32'h000100);
    check("t100_model", {8'h0, bcd_of(m_cnt[0])}, 32'h000100);
    check("t100_ctrl", {29'h0, w_state, w_tenb}, {29'h0, 2'b01, 1'b1});

    // Carry into seconds-tens and into minutes
    ticks(899);
    check("t999_time", {8'h0, w_time}, 32'h000999);
    ticks(1);
    check("t1000_time", {8'h0, w_time}, 32'h001000);
    ticks(4999);
    check("t5999_time", {8'h0, s_time}, 32'h005999);
    ticks(1);
    check("t6000_time", {8'h0, s_time}, 32'h010000);
    check("t6000_model", {8'h0, bcd_of(m_cnt[1])}, 32'h010000);

    // Start, 5 ticks, pause, 10 ticks, resume, 3 ticks -> 00:00.08
    pulse_clr();
    check("clr_time", {8'h0, w_time}, 32'h000000);
    pulse_ss();
    ticks(5);
    pulse_ss();
    check("pause_ctrl", {29'h0, w_state, w_tenb}, {29'h0, 2'b10, 1'b0});
    ticks(10);
    check("pause_hold", {8'h0, w_time}, 32'h000005);
    check("pause_tenb", {31'h0, s_tenb}, 32'h0);
    pulse_ss();
    ticks(3);
    check("resume_time", {8'h0, w_time}, 32'h000008);

    // Clear and start/stop together (plus a tick edge) at 00:00.42
    pulse_clr();
    pulse_ss();
    ticks(42);
    check("t42_time", {8'h0, w_time}, 32'h000042);
    base_tick = 1'b1; clr = 1'b1; ss = 1'b1;
    step();
    base_tick = 1'b0; clr = 1'b0; ss = 1'b0;
    check("clrss_time", {8'h0, w_time}, 32'h000000);
    check("clrss_ctrl", {28'h0, w_state, w_tenb, w_ovf}, 32'h0);

    // Start/stop and a tick edge together while running: tick dropped
    pulse_ss();
    ticks(2);
    base_tick = 1'b1; ss = 1'b1;
    step();
    base_tick = 1'b0; ss = 1'b0;
    step();
    check("ss_drop_time", {8'h0, w_time}, 32'h000002);
    check("ss_drop_state", {30'h0, w_state}, 32'h2);

    // Maximum time: wrap versus saturate, overflow sticky
    preload();
    pulse_ss();
    ticks(2);
    check("max_wrap", {8'h0, w_time}, 32'h595999);
    check("max_sat", {8'h0, s_time}, 32'h595999);
    check("max_novf", {30'h0, w_ovf, s_ovf}, 32'h0);
    ticks(1);
    check("ovf_wrap_time", {8'h0, w_time}, 32'h000000);
    check("ovf_sat_time", {8'h0, s_time}, 32'h595999);
    check("ovf_flags", {30'h0, w_ovf, s_ovf}, 32'h3);
    check("ovf_state", {28'h0, w_state, s_state}, 32'h5);
    ticks(3);
    check("sticky_wrap", {7'h0, w_ovf, w_time}, {7'h0, 1'b1, 24'h000003});
    check("sticky_sat", {7'h0, s_ovf, s_time}, {7'h0, 1'b1, 24'h595999});
    check("sticky_model", {7'h0, m_ovf[0], bcd_of(m_cnt[0])},
          {7'h0, 1'b1, 24'h000003});

    // Reset in the same cycle as a tick edge while running
    base_tick = 1'b1; rst = 1'b1;
    step();
    base_tick = 1'b0; rst = 1'b0;
    check("rst_run_time", {8'h0, w_time}, 32'h000000);
    check("rst_run_sat", {8'h0, s_time}, 32'h000000);
    check("rst_run_ctrl", {28'h0, w_state, w_tenb, w_ovf}, 32'h0);
    check("rst_run_ctrl_s", {28'h0, s_state, s_tenb, s_ovf}, 32'h0);

    // Normal operation after reset
    step();
    pulse_ss();
    ticks(1);
    check("post_rst", {8'h0, w_time}, 32'h000001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
